mul_pg_ctrl: RTL

MUL_PG_CTRL -- requirements
Module: mul_pg_ctrl

---
 rtl/mul_pg_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/mul_pg_ctrl.sv
// Power-gating controller for the multiplier: sequences power switch and result isolation.
// Moore FSM; outputs change only after a clock edge (or immediately on reset).
module mul_pg_ctrl #(
    parameter int WAKE_CYC = 4,
    parameter int IDLE_CYC = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mul_req,
    input  logic       mul_inflight,
    input  logic       pg_dis,
    output logic       pwr_on,
    output logic       pg_mul,
    output logic       mul_rdy,
    output logic [1:0] pg_state
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_ISO  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             act;

    assign act     = mul_req | mul_inflight | pg_dis;
    // Saturating increment keeps an out-of-range parameter from wrapping the counter.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_OFF;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_OFF: begin
                // mul_inflight while unpowered cannot be genuine, so it never wakes the block.
                if (mul_req || pg_dis) begin
                    state_nxt = ST_WAKE;
                    cnt_nxt   = '0;
                end
            end
            ST_WAKE: begin
                if (cnt == WAKE_LAST) begin
                    state_nxt = ST_ON;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_ON: begin
                if (act) begin
                    cnt_nxt = '0;
                end else if (cnt == IDLE_LAST) begin
                    state_nxt = ST_ISO;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_ISO: begin
                // Power is still up here, so late activity returns straight to ON.
                state_nxt = act ? ST_ON : ST_OFF;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = ST_OFF;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        pwr_on  = 1'b0;
        pg_mul  = 1'b0;
        mul_rdy = 1'b0;
        case (state)
            ST_WAKE: pwr_on = 1'b1;
            ST_ON: begin
                pwr_on  = 1'b1;
                pg_mul  = 1'b1;
                mul_rdy = 1'b1;
            end
            ST_ISO:  pwr_on = 1'b1;
            default: ;
        endcase
    end

    assign pg_state = state;

endmodule
